// File: rtl/counter_pkg.sv
// Shared types and tally helpers for the counter subsystem (up- and down-counters).
package counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned COUNTER_WIDTH = 6;

  // Number of even values in 1..n.
  function automatic logic [31:0] even_of(input logic [31:0] n);
    return n >> 1;
  endfunction

  // Number of odd values in 1..n; the +1 is evaluated wide enough not to wrap.
  function automatic logic [31:0] odd_of(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/parity_down_counter.sv
// Loadable down-counter with remaining even/odd tallies and a one-cycle done pulse.
// Optional macro PARITY_DOWN_COUNTER_AUTO_RELOAD_EN: reload the last N on reaching zero and stay in RUN.
module parity_down_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] even_left,
  output logic [WIDTH-1:0] odd_left,
  output logic             busy,
  output logic             done
);

  state_t           r_state,  w_state_nx;
  logic [WIDTH-1:0] r_count,  w_count_nx;
  logic [WIDTH-1:0] r_even,   w_even_nx;
  logic [WIDTH-1:0] r_odd,    w_odd_nx;
  logic             r_done,   w_done_nx;
  logic [WIDTH-1:0] w_load_even, w_load_odd;

`ifdef PARITY_DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload, w_reload_nx;
  logic [WIDTH-1:0] w_rel_even, w_rel_odd;

  assign w_rel_even = WIDTH'(even_of(32'(r_reload)));
  assign w_rel_odd  = WIDTH'(odd_of(32'(r_reload)));
`endif

  assign w_load_even = WIDTH'(even_of(32'(load_value)));
  assign w_load_odd  = WIDTH'(odd_of(32'(load_value)));

  assign load_ready = (r_state == IDLE) && !abort;
  assign busy       = (r_state == RUN);
  assign count      = r_count;
  assign even_left  = r_even;
  assign odd_left   = r_odd;
  assign done       = r_done;

  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    w_even_nx  = r_even;
    w_odd_nx   = r_odd;
    w_done_nx  = 1'b0;
`ifdef PARITY_DOWN_COUNTER_AUTO_RELOAD_EN
    w_reload_nx = r_reload;
`endif
    if (abort) begin
      w_state_nx = IDLE;
      w_count_nx = '0;
      w_even_nx  = '0;
      w_odd_nx   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          // load_ready reduces to "not aborting" here, already established above.
          if (load_valid) begin
`ifdef PARITY_DOWN_COUNTER_AUTO_RELOAD_EN
            w_reload_nx = load_value;
`endif
            if (load_value == '0) begin
              w_done_nx = 1'b1;
            end else begin
              w_state_nx = RUN;
              w_count_nx = load_value;
              w_even_nx  = w_load_even;
              w_odd_nx   = w_load_odd;
            end
          end
        end
        RUN: begin
          if (en) begin
            if (r_count[0] == 1'b0) w_even_nx = r_even - WIDTH'(1);
            else                    w_odd_nx  = r_odd  - WIDTH'(1);
            w_count_nx = r_count - WIDTH'(1);
            if (r_count == WIDTH'(1)) begin
              w_done_nx = 1'b1;
`ifdef PARITY_DOWN_COUNTER_AUTO_RELOAD_EN
              w_count_nx = r_reload;
              w_even_nx  = w_rel_even;
              w_odd_nx   = w_rel_odd;
`else
              w_state_nx = IDLE;
`endif
            end
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_count <= '0;
      r_even  <= '0;
      r_odd   <= '0;
      r_done  <= 1'b0;
`ifdef PARITY_DOWN_COUNTER_AUTO_RELOAD_EN
      r_reload <= '0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_count <= w_count_nx;
      r_even  <= w_even_nx;
      r_odd   <= w_odd_nx;
      r_done  <= w_done_nx;
`ifdef PARITY_DOWN_COUNTER_AUTO_RELOAD_EN
      r_reload <= w_reload_nx;
`endif
    end
  end

endmodule

// File: tb/tb_parity_down_counter.sv
// Bench for parity_down_counter: directed plan plus random traffic against a counting reference model.
module tb_parity_down_counter;
  import counter_pkg::*;

  localparam int unsigned W = COUNTER_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         load_ready;
  logic         en = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] count, even_left, odd_left;
  logic         busy, done;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Reference model: remaining count and phase only; tallies are recounted from 1..count.
  bit          m_run  = 1'b0;
  bit          m_done = 1'b0;
  int unsigned m_count = 0;
`ifdef PARITY_DOWN_COUNTER_AUTO_RELOAD_EN
  int unsigned m_reload = 0;
`endif

  parity_down_counter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .en         (en),
    .abort      (abort),
    .count      (count),
    .even_left  (even_left),
    .odd_left   (odd_left),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic int unsigned evens_upto(input int unsigned c);
    int unsigned k = 0;
    for (int unsigned v = 1; v <= c; v++) if (v % 2 == 0) k++;
    return k;
  endfunction

  function automatic int unsigned odds_upto(input int unsigned c);
    int unsigned k = 0;
    for (int unsigned v = 1; v <= c; v++) if (v % 2 == 1) k++;
    return k;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("count",     32'(count),     m_count);
    chk("even_left", 32'(even_left), evens_upto(m_count));
    chk("odd_left",  32'(odd_left),  odds_upto(m_count));
    chk("busy",      32'(busy),      32'(m_run));
    chk("done",      32'(done),      32'(m_done));
  endtask

  task automatic model_reset();
    m_run   = 1'b0;
    m_done  = 1'b0;
    m_count = 0;
`ifdef PARITY_DOWN_COUNTER_AUTO_RELOAD_EN
    m_reload = 0;
`endif
  endtask

  // One clock: drive inputs, check load_ready, advance model, check registered outputs.
  task automatic step(input logic lv, input logic [W-1:0] lval, input logic e, input logic ab);
    int unsigned n;
    load_valid = lv;
    load_value = lval;
    en         = e;
    abort      = ab;
    #1;
    chk("load_ready", 32'(load_ready), 32'(!m_run && !ab));
    n = int'(lval);
    if (ab) begin
      m_run = 1'b0; m_count = 0; m_done = 1'b0;
    end else if (!m_run) begin
      m_done = 1'b0;
      if (lv) begin
`ifdef PARITY_DOWN_COUNTER_AUTO_RELOAD_EN
        m_reload = n;
`endif
        if (n == 0) m_done = 1'b1;
        else begin m_run = 1'b1; m_count = n; end
      end
    end else begin
      m_done = 1'b0;
      if (e) begin
        m_count = m_count - 1;
        if (m_count == 0) begin
          m_done = 1'b1;
`ifdef PARITY_DOWN_COUNTER_AUTO_RELOAD_EN
          m_count = m_reload;
`else
          m_run = 1'b0;
`endif
        end
      end
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  int unsigned lat;
  int unsigned pulses;

  initial begin
    // Reset
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", 32'(load_ready), 32'd1);

    // N=5 with en high, then back-to-back load of N=2 in the done cycle
    step(1'b1, W'(5), 1'b1, 1'b0);
    chk("n5_count", 32'(count), 32'd5);
    chk("n5_even",  32'(even_left), 32'd2);
    chk("n5_odd",   32'(odd_left), 32'd3);
    repeat (5) step(1'b0, '0, 1'b1, 1'b0);
    chk("n5_done_pulse", 32'(done), 32'd1);
    step(1'b1, W'(2), 1'b1, 1'b0);
`ifndef PARITY_DOWN_COUNTER_AUTO_RELOAD_EN
    chk("b2b_load_count", 32'(count), 32'd2);
`endif
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);

    // N=0: immediate done, never busy
    step(1'b1, '0, 1'b1, 1'b0);
    chk("n0_done", 32'(done), 32'd1);
    chk("n0_busy", 32'(busy), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);

    // N=4 with en dropped for two cycles at count=3
    step(1'b1, W'(4), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("n4_hold_count", 32'(count), 32'd3);
    lat = 3;
    while (done !== 1'b1 && lat < 50) begin
      step(1'b0, '0, 1'b1, 1'b0);
      lat++;
    end
    chk("n4_latency", lat, 32'd6);
    step(1'b0, '0, 1'b0, 1'b1);

    // N=63: full-scale tallies and latency
    step(1'b1, W'(63), 1'b1, 1'b0);
    chk("n63_even", 32'(even_left), 32'd31);
    chk("n63_odd",  32'(odd_left),  32'd32);
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      step(1'b0, '0, 1'b1, 1'b0);
      lat++;
    end
    chk("n63_latency", lat, 32'd63);
    step(1'b0, '0, 1'b0, 1'b1);

    // Abort at count=2 with a concurrent load offered
    step(1'b1, W'(7), 1'b1, 1'b0);
    repeat (5) step(1'b0, '0, 1'b1, 1'b0);
    chk("abort_pre_count", 32'(count), 32'd2);
    step(1'b1, W'(9), 1'b1, 1'b1);
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_busy",  32'(busy),  32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("abort_no_done", 32'(done), 32'd0);

    // Asynchronous reset mid-RUN
    step(1'b1, W'(7), 1'b1, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);

`ifdef PARITY_DOWN_COUNTER_AUTO_RELOAD_EN
    // Auto-reload: periodic done, no loads accepted while running
    step(1'b1, W'(3), 1'b1, 1'b0);
    pulses = 0;
    repeat (12) begin
      step(1'b1, W'(5), 1'b1, 1'b0);
      if (done === 1'b1) pulses++;
    end
    chk("reload_pulses", pulses, 32'd4);
    chk("reload_busy", 32'(busy), 32'd1);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
`endif

    // Random traffic, biased toward short counts so completions are frequent
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] v;
      v = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 8)) : W'($urandom);
      step(1'($urandom_range(0, 1)), v, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
